// File: rtl/timer_irq_dev.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes driving a CP0 HWInt line.
// Optional macro TIMER_IRQ_ACK_EN adds a dedicated irq_ack input in place of the CTRL-write acknowledge.
module timer_irq_dev #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000,
  parameter int          CTRL_W     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
`ifdef TIMER_IRQ_ACK_EN
  input  logic        irq_ack,
`endif
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CNT = 2'd1, S_INT = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [31:0]         r_preset, r_count;
  logic                r_irq_pend;

  logic w_ctrl_wr, w_preset_wr, w_en, w_reload, w_im, w_expire;
  logic w_load, w_dec, w_zero, w_pend_set, w_pend_drop, w_en_clr, w_pend_clr_sw;

  assign w_ctrl_wr   = we && (addr == 2'd0);
  assign w_preset_wr = we && (addr == 2'd1);
  assign w_en        = r_ctrl[0];
  assign w_reload    = (r_ctrl[2:1] == 2'b01);
  assign w_im        = r_ctrl[3];
  assign w_expire    = (r_count <= 32'd1);

`ifdef TIMER_IRQ_ACK_EN
  assign w_pend_clr_sw = irq_ack;
`else
  assign w_pend_clr_sw = w_ctrl_wr;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_en) w_state_nxt = S_CNT;
      S_CNT:   if (!w_en) w_state_nxt = S_IDLE;
               else if (w_expire) w_state_nxt = S_INT;
      S_INT:   w_state_nxt = w_reload ? S_CNT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_zero      = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_drop = 1'b0;
    w_en_clr    = 1'b0;
    case (r_state)
      S_IDLE: w_load = w_en;
      S_CNT: begin
        w_dec      = w_en && !w_expire;
        w_zero     = w_en && w_expire;
        w_pend_set = w_en && w_expire;
      end
      S_INT: begin
        // Auto-reload emits a one-cycle pulse; one-shot leaves the level for software.
        w_load      = w_reload;
        w_pend_drop = w_reload;
        w_en_clr    = !w_reload;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl     <= '0;
      r_preset   <= PRESET_RST;
      r_count    <= '0;
      r_irq_pend <= 1'b0;
    end else begin
      if (w_ctrl_wr)     r_ctrl    <= wdata[CTRL_W-1:0];
      else if (w_en_clr) r_ctrl[0] <= 1'b0;
      if (w_preset_wr) r_preset <= wdata;
      if (w_load)      r_count  <= r_preset;
      else if (w_dec)  r_count  <= r_count - 32'd1;
      else if (w_zero) r_count  <= '0;
      // Software clear beats a same-edge expiry.
      if (w_pend_clr_sw)    r_irq_pend <= 1'b0;
      else if (w_pend_set)  r_irq_pend <= 1'b1;
      else if (w_pend_drop) r_irq_pend <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
      2'd1:    rdata = r_preset;
      2'd2:    rdata = r_count;
      default: rdata = '0;
    endcase
  end

  assign irq = r_irq_pend & w_im;

endmodule

// File: tb/tb_timer_irq_dev.sv
// Directed + random bench for timer_irq_dev against a spec-level reference model.
module tb_timer_irq_dev;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  timer_irq_dev dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .we(we), .wdata(wdata),
`ifdef TIMER_IRQ_ACK_EN
    .irq_ack(ack),
`endif
    .rdata(rdata), .irq(irq)
  );

  always #10 clk = ~clk;

  // Reference model: phase 0 = idle, 1 = counting, 2 = expired
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  logic        m_pend;
  int          m_phase;

  task automatic model_reset();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_pend = 1'b0; m_phase = 0;
  endtask

  task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d, input logic k);
    logic [3:0]  nc;
    logic [31:0] np, ncount;
    logic        npend;
    int          nph;
    nc = m_ctrl; np = m_preset; ncount = m_count; npend = m_pend; nph = m_phase;
    if (m_phase == 0) begin
      if (m_ctrl[0]) begin ncount = m_preset; nph = 1; end
    end else if (m_phase == 1) begin
      if (!m_ctrl[0]) nph = 0;
      else if (m_count > 1) ncount = m_count - 1;
      else begin ncount = 0; npend = 1'b1; nph = 2; end
    end else begin
      if (m_ctrl[2:1] == 2'b01) begin npend = 1'b0; ncount = m_preset; nph = 1; end
      else begin nc[0] = 1'b0; nph = 0; end
    end
    if (w && a == 2'd0) begin
      nc = d[3:0];
`ifndef TIMER_IRQ_ACK_EN
      npend = 1'b0;
`endif
    end
    if (w && a == 2'd1) np = d;
    if (k) npend = 1'b0;
    m_ctrl = nc; m_preset = np; m_count = ncount; m_pend = npend; m_phase = nph;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e [4];
    e[0] = {28'd0, m_ctrl}; e[1] = m_preset; e[2] = m_count; e[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      #1;
      chk($sformatf("%s_reg%0d", tag, i), rdata, e[i]);
    end
    chk({tag, "_irq"}, {31'd0, irq}, {31'd0, m_pend & m_ctrl[3]});
    addr = 2'd0;
  endtask

  task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
    we = w; addr = a; wdata = d;
    @(posedge clk);
    model_edge(w, a, d, ack);
    #1;
    we = 1'b0; ack = 1'b0;
    check_all("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a; #1; v = rdata;
  endtask

  logic [31:0] v;
  int exp_os [4];
  int exp_ar [6];

  initial begin
    reset_n = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0; ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("rst");
    reset_n = 1'b1;

    // Reset asserted mid-count
    step(1'b1, 2'd1, 32'd5);
    step(1'b1, 2'd0, 32'd9);
    idle(3);
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 check_all("rst_mid");
    rd(2'd2, v); chk("rst_mid_count", v, 32'd0);
    reset_n = 1'b1;
    idle(2);
    rd(2'd2, v); chk("rst_idle_count", v, 32'd0);

    // One-shot
    exp_os = '{3, 2, 1, 0};
    step(1'b1, 2'd1, 32'd3);
    step(1'b1, 2'd0, 32'h9);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      rd(2'd2, v); chk("os_count", v, 32'(exp_os[i]));
    end
    chk("os_irq_E4", {31'd0, irq}, 32'd1);
    idle(1);
    rd(2'd0, v); chk("os_en_cleared", {31'd0, v[0]}, 32'd0);
    chk("os_irq_held", {31'd0, irq}, 32'd1);
    step(1'b1, 2'd0, 32'd0);
    chk("os_irq_cleared", {31'd0, irq}, 32'd0);

    // Auto-reload
    exp_ar = '{2, 1, 0, 2, 1, 0};
    step(1'b1, 2'd1, 32'd2);
    step(1'b1, 2'd0, 32'hB);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      rd(2'd2, v); chk("ar_count", v, 32'(exp_ar[i]));
      chk("ar_irq", {31'd0, irq}, (i == 2 || i == 5) ? 32'd1 : 32'd0);
    end
    step(1'b1, 2'd0, 32'd0);

    // Mask
    step(1'b1, 2'd1, 32'd1);
    step(1'b1, 2'd0, 32'h1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("mask_irq", {31'd0, irq}, 32'd0);
    end
    step(1'b1, 2'd0, 32'h8);
`ifndef TIMER_IRQ_ACK_EN
    chk("mask_unmask_irq", {31'd0, irq}, 32'd0);
`else
    ack = 1'b1;
    idle(1);
`endif
    step(1'b1, 2'd0, 32'd0);

    // Pause and PRESET change
    step(1'b1, 2'd1, 32'd10);
    step(1'b1, 2'd0, 32'h1);
    idle(4);
    step(1'b1, 2'd0, 32'd0);
    idle(3);
    rd(2'd2, v); chk("pause_hold", v, 32'd6);
    step(1'b1, 2'd1, 32'd4);
    rd(2'd2, v); chk("pause_preset_nochg", v, 32'd6);
    step(1'b1, 2'd0, 32'h1);
    idle(1);
    rd(2'd2, v); chk("pause_reload", v, 32'd4);
    step(1'b1, 2'd0, 32'd0);
    idle(2);

    // PRESET = 0 behaves as 1
    step(1'b1, 2'd1, 32'd0);
    step(1'b1, 2'd0, 32'h9);
    idle(1);
    chk("p0_irq_E1", {31'd0, irq}, 32'd0);
    idle(1);
    chk("p0_irq_E2", {31'd0, irq}, 32'd1);
    step(1'b1, 2'd0, 32'd0);
    ack = 1'b1;
    idle(2);

    // Collision of software clear with expiry
    step(1'b1, 2'd1, 32'd2);
    step(1'b1, 2'd0, 32'h9);
    idle(2);
`ifndef TIMER_IRQ_ACK_EN
    step(1'b1, 2'd0, 32'h8);
    chk("coll_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, v); chk("coll_ctrl", v, 32'h8);
`else
    ack = 1'b1;
    idle(1);
    chk("coll_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, v); chk("coll_ctrl", v, 32'h9);
`endif
    step(1'b1, 2'd0, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      w = ($urandom_range(0, 5) == 0);
      a = 2'($urandom_range(0, 3));
      d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
`ifdef TIMER_IRQ_ACK_EN
      ack = ($urandom_range(0, 7) == 0);
`endif
      step(w, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
